// File: rtl/battle_controller.sv
// Turn-based battle engine: debounced switch commands drive a player/enemy turn FSM with HP and turn bookkeeping.
// Command edge to HP/msg update is 1 clk; raw switch to debounced edge is DB_CYCLES+2 clks.
module battle_controller #(
    parameter logic [7:0] PLAYER_HP_MAX = 8'd100,
    parameter logic [7:0] ENEMY_HP_MAX  = 8'd80,
    parameter logic [7:0] PLAYER_ATK    = 8'd12,
    parameter logic [7:0] ENEMY_ATK     = 8'd9,
    parameter logic [7:0] HEAL_AMT      = 8'd20,
    parameter int         DB_CYCLES     = 250000,
    parameter int         MSG_FRAMES    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] switch,
    input  logic       frame_tick,
    output logic [2:0] phase,
    output logic [3:0] msg_id,
    output logic [7:0] player_hp,
    output logic [7:0] enemy_hp,
    output logic [7:0] turn_count
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int HW  = $clog2(MSG_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        P_TURN = 3'd1,
        P_SHOW = 3'd2,
        E_ACT  = 3'd3,
        E_SHOW = 3'd4,
        WIN    = 3'd5,
        LOSE   = 3'd6
    } state_t;

    // Used switches packed as {start, defend, heal, attack}
    logic [3:0]     sync1_q, sync2_q, db_q, db_d, dbp_q, cmd_edge;
    logic [DBW-1:0] cnt_q [4];
    logic [DBW-1:0] cnt_d [4];
    logic [DBW-1:0] arm_cnt_q, arm_cnt_d;
    logic           armed_q, armed_d;

    state_t         state_q, state_d;
    logic [3:0]     msg_q, msg_d;
    logic [7:0]     php_q, php_d, ehp_q, ehp_d, turn_q, turn_d;
    logic           def_q, def_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           hold_done;
    logic [8:0]     heal_sum;
    logic [7:0]     e_dmg;

    // Before arming, levels follow the synchroniser so a switch held through reset never yields an edge
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (!armed_q) begin
            if (arm_cnt_q == DBW'(DB_CYCLES - 1)) armed_d = 1'b1;
            else arm_cnt_d = arm_cnt_q + DBW'(1);
        end
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (!armed_q) begin
                db_d[i] = sync2_q[i];
            end else if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DBW'(DB_CYCLES - 1)) db_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + DBW'(1);
            end
        end
    end

    assign cmd_edge  = db_q & ~dbp_q & {4{armed_q}};
    assign hold_done = frame_tick && (hold_q == HW'(MSG_FRAMES - 1));
    assign heal_sum  = {1'b0, php_q} + {1'b0, HEAL_AMT};
    assign e_dmg     = def_q ? (ENEMY_ATK >> 1) : ENEMY_ATK;

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        php_d   = php_q;
        ehp_d   = ehp_q;
        turn_d  = turn_q;
        def_d   = def_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: if (cmd_edge[3]) state_d = P_TURN;
            P_TURN: begin
                hold_d = '0;
                if (cmd_edge[0]) begin
                    ehp_d   = (ehp_q > PLAYER_ATK) ? ehp_q - PLAYER_ATK : 8'd0;
                    msg_d   = 4'd1;
                    state_d = P_SHOW;
                end else if (cmd_edge[1]) begin
                    php_d   = (heal_sum > {1'b0, PLAYER_HP_MAX}) ? PLAYER_HP_MAX : heal_sum[7:0];
                    msg_d   = 4'd2;
                    state_d = P_SHOW;
                end else if (cmd_edge[2]) begin
                    def_d   = 1'b1;
                    msg_d   = 4'd3;
                    state_d = P_SHOW;
                end
            end
            P_SHOW: begin
                if (frame_tick) hold_d = hold_q + HW'(1);
                if (hold_done) begin
                    if (ehp_q == 8'd0) begin
                        state_d = WIN;
                        msg_d   = 4'd5;
                    end else begin
                        state_d = E_ACT;
                    end
                end
            end
            E_ACT: begin
                php_d   = (php_q > e_dmg) ? php_q - e_dmg : 8'd0;
                def_d   = 1'b0;
                msg_d   = 4'd4;
                hold_d  = '0;
                state_d = E_SHOW;
            end
            E_SHOW: begin
                if (frame_tick) hold_d = hold_q + HW'(1);
                if (hold_done) begin
                    if (php_q == 8'd0) begin
                        state_d = LOSE;
                        msg_d   = 4'd6;
                    end else begin
                        if (turn_q != 8'hFF) turn_d = turn_q + 8'd1;
                        state_d = P_TURN;
                    end
                end
            end
            WIN, LOSE: begin
                if (cmd_edge[3]) begin
                    state_d = IDLE;
                    msg_d   = 4'd0;
                    php_d   = PLAYER_HP_MAX;
                    ehp_d   = ENEMY_HP_MAX;
                    turn_d  = 8'd0;
                    def_d   = 1'b0;
                    hold_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            dbp_q     <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
            state_q   <= IDLE;
            msg_q     <= 4'd0;
            php_q     <= PLAYER_HP_MAX;
            ehp_q     <= ENEMY_HP_MAX;
            turn_q    <= 8'd0;
            def_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            sync1_q   <= {switch[6], switch[2:0]};
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            dbp_q     <= db_q;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            msg_q     <= msg_d;
            php_q     <= php_d;
            ehp_q     <= ehp_d;
            turn_q    <= turn_d;
            def_q     <= def_d;
            hold_q    <= hold_d;
        end
    end

    assign phase      = state_q;
    assign msg_id     = msg_q;
    assign player_hp  = php_q;
    assign enemy_hp   = ehp_q;
    assign turn_count = turn_q;
endmodule

// File: tb/tb_battle_controller.sv
// Directed bench for battle_controller with short debounce (4) and message hold (2 frames).
module tb_battle_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] switch = '0;
    logic       frame_tick = 1'b0;
    logic [2:0] phase;
    logic [3:0] msg_id;
    logic [7:0] player_hp, enemy_hp, turn_count;
    int nerr = 0;
    int nchk = 0;

    battle_controller #(.DB_CYCLES(4), .MSG_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .switch(switch), .frame_tick(frame_tick),
        .phase(phase), .msg_id(msg_id), .player_hp(player_hp),
        .enemy_hp(enemy_hp), .turn_count(turn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the given switches long enough to debounce, then release and let them settle low
    task automatic press(input logic [6:0] mask);
        switch = switch | mask;
        wait_clks(8);
        switch = switch & ~mask;
        wait_clks(8);
    endtask

    task automatic tick2();
        repeat (2) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic attack_round(input string tag, input logic [7:0] e_exp,
                                input logic [7:0] p_exp, input logic [7:0] t_exp);
        press(7'h01);
        chk({tag, "_ehp"}, enemy_hp, e_exp);
        tick2();
        chk({tag, "_php"}, player_hp, p_exp);
        tick2();
        chk({tag, "_turn"}, turn_count, t_exp);
    endtask

    initial begin
        wait_clks(3);
        rst = 1'b0;
        wait_clks(8);
        chk("rst_phase", phase, 0);
        chk("rst_msg", msg_id, 0);
        chk("rst_php", player_hp, 100);
        chk("rst_ehp", enemy_hp, 80);
        chk("rst_turn", turn_count, 0);

        press(7'h40);
        chk("start_phase", phase, 1);

        // Round 1: attack
        press(7'h01);
        chk("r1_phase", phase, 2);
        chk("r1_ehp", enemy_hp, 68);
        chk("r1_msg", msg_id, 1);
        tick2();
        chk("r1_eshow", phase, 4);
        chk("r1_php", player_hp, 91);
        chk("r1_emsg", msg_id, 4);
        tick2();
        chk("r1_back", phase, 1);
        chk("r1_turn", turn_count, 1);

        // Round 2: defend halves enemy damage to 4
        press(7'h04);
        chk("r2_msg", msg_id, 3);
        tick2();
        chk("r2_php", player_hp, 87);
        tick2();
        chk("r2_turn", turn_count, 2);

        // Round 3: heal capped at 100
        press(7'h02);
        chk("r3_php_cap", player_hp, 100);
        chk("r3_msg", msg_id, 2);
        tick2();
        chk("r3_php", player_hp, 91);
        tick2();

        // Round 4: attack and heal together, only attack applies
        press(7'h03);
        chk("r4_ehp", enemy_hp, 56);
        chk("r4_php", player_hp, 91);
        chk("r4_msg", msg_id, 1);
        tick2();
        chk("r4_php2", player_hp, 82);
        tick2();

        // Round 5: bouncing attack switch shorter than the debounce window
        repeat (5) begin
            switch[0] = 1'b1;
            wait_clks(2);
            switch[0] = 1'b0;
            wait_clks(2);
        end
        wait_clks(8);
        chk("bounce_phase", phase, 1);
        chk("bounce_ehp", enemy_hp, 56);
        attack_round("r5", 8'd44, 8'd73, 8'd5);

        // Round 6: uncapped heal
        press(7'h02);
        chk("r6_php_heal", player_hp, 93);
        tick2();
        chk("r6_php", player_hp, 84);
        tick2();

        // Round 7: start in P_TURN is ignored
        press(7'h40);
        chk("start_ignored", phase, 1);
        attack_round("r7", 8'd32, 8'd75, 8'd7);
        attack_round("r8", 8'd20, 8'd66, 8'd8);
        attack_round("r9", 8'd8, 8'd57, 8'd9);

        // Round 10: enemy at 8 takes 12 and stops at 0
        press(7'h01);
        chk("r10_ehp", enemy_hp, 0);
        tick2();
        chk("win_phase", phase, 5);
        chk("win_msg", msg_id, 5);
        chk("win_turn", turn_count, 9);
        press(7'h40);
        chk("restart_phase", phase, 0);
        chk("restart_php", player_hp, 100);
        chk("restart_ehp", enemy_hp, 80);
        chk("restart_turn", turn_count, 0);
        chk("restart_msg", msg_id, 0);

        // Attack switch held through reset must not fire
        switch[0] = 1'b1;
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(10);
        press(7'h40);
        chk("held_phase", phase, 1);
        chk("held_ehp", enemy_hp, 80);
        switch[0] = 1'b0;
        wait_clks(8);
        chk("held_rel_phase", phase, 1);
        chk("held_rel_ehp", enemy_hp, 80);

        // Asynchronous reset in E_SHOW
        press(7'h01);
        tick2();
        chk("pre_rst_phase", phase, 4);
        chk("pre_rst_php", player_hp, 91);
        rst = 1'b1;
        #1;
        chk("async_phase", phase, 0);
        chk("async_php", player_hp, 100);
        chk("async_ehp", enemy_hp, 80);
        chk("async_msg", msg_id, 0);
        wait_clks(2);
        rst = 1'b0;
        wait_clks(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
